mul_div_unit: RTL and testbench

- Iterative 16-bit unsigned multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read operands and produces a 32-bit result.
- Low half (product low / quotient) returns through the normal write port; high half (product high / remainder) returns through the dedicated R0 write port.
- Asserts stall while iterating so the pipeline holds.

---
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/mul_div_unit.sv | 127 ++++++++++++
 tb/tb_mul_div_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Operand / result bundle between the issue logic and the iterative multiply/divide unit.
// The master side drives requests and operands; the slave side returns results and write strobes.
interface mul_div_unit_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [AW-1:0]    wa_in;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div0;
  logic             reg_write;
  logic [AW-1:0]    wa_out;
  logic [WIDTH-1:0] wd_out;
  logic             r0_write;
  logic [WIDTH-1:0] r0_data;

  modport master (
    output start, op, rd1, rd2, wa_in,
    input  busy, stall, done, div0, reg_write, wa_out, wd_out, r0_write, r0_data
  );

  modport slave (
    input  start, op, rd1, rd2, wa_in,
    output busy, stall, done, div0, reg_write, wa_out, wd_out, r0_write, r0_data
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per clock.
// Low result goes out on the normal write port, high result on the R0 port.
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] b_q, b_d;        // multiplicand (mul) or divisor (div), held constant
  logic [WIDTH-1:0] lo_q, lo_d;      // multiplier shifting out / quotient shifting in
  logic [WIDTH:0]   hi_q, hi_d;      // accumulator / working remainder with carry bit
  logic [AW-1:0]    wa_out_q, wa_out_d;
  logic [WIDTH-1:0] wd_out_q, wd_out_d;
  logic [WIDTH-1:0] r0_data_q, r0_data_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   divisor_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      div0_q    <= 1'b0;
      b_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      wa_out_q  <= '0;
      wd_out_q  <= '0;
      r0_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      div0_q    <= div0_d;
      b_q       <= b_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      wa_out_q  <= wa_out_d;
      wd_out_q  <= wd_out_d;
      r0_data_q <= r0_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    div0_d      = div0_q;
    b_d         = b_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    wa_out_d    = wa_out_q;
    wd_out_d    = wd_out_q;
    r0_data_d   = r0_data_q;
    divisor_ext = {1'b0, b_q};
    mul_sum     = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh      = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = CALC;
          cnt_d    = CW'(WIDTH);
          op_d     = bus.op;
          div0_d   = bus.op && (bus.rd2 == '0);
          wa_out_d = bus.wa_in;
          hi_d     = '0;
          // Divide keeps the divisor fixed and shifts the dividend; multiply the reverse.
          b_d      = bus.op ? bus.rd2 : bus.rd1;
          lo_d     = bus.op ? bus.rd1 : bus.rd2;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (!op_q) begin
            hi_d = {1'b0, mul_sum[WIDTH:1]};
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end else if (rem_sh >= divisor_ext) begin
            hi_d = rem_sh - divisor_ext;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rem_sh;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d   = DONE;
          wd_out_d  = lo_q;
          r0_data_d = hi_q[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode straight from state so an asynchronous reset clears them at once.
  assign bus.busy      = (state_q == CALC);
  assign bus.stall     = (state_q == CALC);
  assign bus.done      = (state_q == DONE);
  assign bus.reg_write = (state_q == DONE);
  assign bus.r0_write  = (state_q == DONE);
  assign bus.div0      = (state_q == DONE) && div0_q;
  assign bus.wa_out    = wa_out_q;
  assign bus.wd_out    = wd_out_q;
  assign bus.r0_data   = r0_data_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, results, div-by-zero, busy rejection and async reset.
module tb_mul_div_unit;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_failed;

  mul_div_unit_if #(.WIDTH(16), .AW(4)) bus ();

  mul_div_unit #(.WIDTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and checks latency, busy span, results and strobes.
  // With inject set, a second start with other operands is pulsed 5 cycles in.
  task automatic run_op(input string name, input logic op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] wa,
                        input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                        input logic exp_div0, input bit inject);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rd1   = a;
    bus.rd2   = b;
    bus.wa_in = wa;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rd1   = ~a;
    bus.rd2   = ~b;
    bus.wa_in = ~wa;
    busy_cnt  = bus.busy ? 1 : 0;
    lat       = 0;
    for (int k = 1; k <= 40; k++) begin
      if (inject && k == 5) begin
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.rd1   = 16'h0F0F;
        bus.rd2   = 16'h0003;
      end
      if (inject && k == 6) bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    check({name, "_latency"}, lat, 17);
    check({name, "_busy_cycles"}, busy_cnt, 17);
    check({name, "_wd_out"}, bus.wd_out, exp_lo);
    check({name, "_r0_data"}, bus.r0_data, exp_hi);
    check({name, "_wa_out"}, bus.wa_out, wa);
    check({name, "_div0"}, bus.div0, exp_div0);
    check({name, "_strobes"}, {bus.reg_write, bus.r0_write, bus.busy, bus.stall}, 4'b1100);
    @(negedge clk);
    check({name, "_strobes_drop"}, {bus.done, bus.reg_write, bus.r0_write, bus.div0}, 4'b0000);
    check({name, "_wd_hold"}, {bus.wd_out, bus.r0_data}, {exp_lo, exp_hi});
    $display("[TB] %s op=%0d a=0x%04h b=0x%04h -> wd=0x%04h r0=0x%04h div0=%0d lat=%0d",
             name, op, a, b, exp_lo, exp_hi, exp_div0, lat);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    n_tests   = 0;
    n_failed  = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.rd1   = 16'h1111;
    bus.rd2   = 16'h2222;
    bus.wa_in = 4'd3;
    repeat (3) @(negedge clk);
    check("reset_strobes", {bus.busy, bus.stall, bus.done, bus.div0, bus.reg_write, bus.r0_write}, 6'b0);
    check("reset_data", {bus.wa_out, bus.wd_out, bus.r0_data}, 36'h0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {bus.busy, bus.done}, 2'b00);

    run_op("mul",     1'b0, 16'h1234, 16'h0010, 4'd4, 16'h2340, 16'h0001, 1'b0, 1'b0);
    run_op("mul_max", 1'b0, 16'hFFFF, 16'hFFFF, 4'd9, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
    run_op("div",     1'b1, 16'h0064, 16'h0007, 4'd5, 16'h000E, 16'h0002, 1'b0, 1'b0);
    run_op("div0",    1'b1, 16'h1234, 16'h0000, 4'd0, 16'hFFFF, 16'h1234, 1'b1, 1'b0);

    run_op("busy_rej", 1'b0, 16'h00FF, 16'h0101, 4'd6, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    expect_no_done("busy_rej_no_second_done", 25);
    run_op("after_rej", 1'b0, 16'h0003, 16'h0005, 4'd7, 16'h000F, 16'h0000, 1'b0, 1'b0);

    // Reset asserted mid-CALC, away from any clock edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.rd1   = 16'hABCD;
    bus.rd2   = 16'h1357;
    bus.wa_in = 4'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("midop_busy", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_strobes", {bus.busy, bus.stall, bus.done, bus.div0, bus.reg_write, bus.r0_write}, 6'b0);
    check("async_rst_data", {bus.wa_out, bus.wd_out, bus.r0_data}, 36'h0);
    @(negedge clk);
    rst = 1'b0;
    expect_no_done("rst_no_done", 25);
    run_op("div_after_rst", 1'b1, 16'h0064, 16'h0007, 4'd5, 16'h000E, 16'h0002, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule
